// File: rtl/maxval_pkg.sv
// Shared types and constants for the BRAM job master and its accelerator-side peers.
package maxval_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        WAIT_CLR,
        RD_ADDR,
        RD_DATA
    } state_t;

    localparam int CTRL_START_BIT  = 0;
    localparam int STATUS_DONE_BIT = 0;

    localparam int DEF_NWORDS  = 2048;
    localparam int DEF_ADDR_W  = 13;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 65535;

endpackage

// File: rtl/wait_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module wait_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    // Count down from the loaded value and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/bram_job_master.sv
// Fabric-side initiator: streams NWORDS words into the accelerator BRAM,
// runs the start/done handshake, then reads the result word from address 0.
//
//   state     | meaning
//   IDLE      | waiting for cmd_start
//   LOAD      | accepting stream words, writing ascending BRAM addresses
//   START     | last write issued; raise start
//   WAIT_DONE | start held high until done (or timeout)
//   WAIT_CLR  | start low, waiting for done to clear (or timeout)
//   RD_ADDR   | BRAM read of address 0 is on the port
//   RD_DATA   | read data valid; capture into result
//
// Every BRAM-side output and the start bit are flops, so the combinational
// block computes their next values and the register block loads them.
// The read of address 0 is launched on the transition into RD_ADDR so the
// 1-cycle BRAM latency lands the data in RD_DATA.
module bram_job_master
    import maxval_pkg::*;
#(
    parameter int NWORDS  = DEF_NWORDS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_start,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic [31:0]         ps_control,
    input  logic [31:0]         pl_status,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_wrdata,
    output logic [DATA_W/8-1:0] bram_we,
    output logic                bram_en,
    input  logic [DATA_W-1:0]   bram_rddata,
    output logic [DATA_W-1:0]   result,
    output logic                result_valid,
    output logic                error
);

    localparam int CNT_W = $clog2(NWORDS);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int BE_W  = DATA_W / 8;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                start_q, start_n;
    logic                en_n;
    logic [BE_W-1:0]     we_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wrdata_n;
    logic [DATA_W-1:0]   result_n;
    logic                rv_n;
    logic                err_n;
    logic                tmr_load;
    logic                tmr_expired;
    logic                done;
    logic                unused_status;

    assign done          = pl_status[STATUS_DONE_BIT];
    assign unused_status = ^pl_status;
    assign busy          = (state != IDLE);
    assign in_ready      = (state == LOAD);

    // Start bit is the only live control bit; the rest read as zero.
    always_comb begin
        ps_control                 = '0;
        ps_control[CTRL_START_BIT] = start_q;
    end

    // One timer serves both wait states; it is reloaded on entry to each.
    wait_timer #(.W(TMR_W)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TMR_W'(TIMEOUT - 1)),
        .expired  (tmr_expired)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        start_n  = start_q;
        en_n     = 1'b0;
        we_n     = '0;
        addr_n   = '0;
        wrdata_n = '0;
        result_n = result;
        rv_n     = 1'b0;
        err_n    = 1'b0;
        tmr_load = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_start) begin
                    cnt_n   = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    en_n     = 1'b1;
                    we_n     = '1;
                    addr_n   = ADDR_W'({cnt, 2'b00});
                    wrdata_n = in_data;
                    cnt_n    = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NWORDS - 1)) begin
                        state_n = START;
                    end
                end
            end
            START: begin
                start_n  = 1'b1;
                tmr_load = 1'b1;
                state_n  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    start_n  = 1'b0;
                    tmr_load = 1'b1;
                    state_n  = WAIT_CLR;
                end else if (tmr_expired) begin
                    start_n = 1'b0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_CLR: begin
                if (!done) begin
                    en_n    = 1'b1;
                    state_n = RD_ADDR;
                end else if (tmr_expired) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_ADDR: begin
                state_n = RD_DATA;
            end
            RD_DATA: begin
                result_n = bram_rddata;
                rv_n     = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            start_q      <= 1'b0;
            bram_en      <= 1'b0;
            bram_we      <= '0;
            bram_addr    <= '0;
            bram_wrdata  <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            start_q      <= start_n;
            bram_en      <= en_n;
            bram_we      <= we_n;
            bram_addr    <= addr_n;
            bram_wrdata  <= wrdata_n;
            result       <= result_n;
            result_valid <= rv_n;
            error        <= err_n;
        end
    end

endmodule

// File: doc/bram_job_master.md
Name: bram_job_master

Overview:
- Hardware initiator for the PL accelerator control/BRAM interface: the PS-side master of a maxval-style accelerator, implemented in fabric.
- Fills the accelerator's BRAM port with NWORDS words taken from a valid/ready input stream.
- Runs the level-sensitive ps_control/pl_status start/done handshake, then reads the result word back from BRAM address 0.
- Sits between a data source (DMA or stream FIFO) and an accelerator wrapper, replacing software-driven AXI BRAM controller accesses.

Parameters:
- NWORDS, 2048, words loaded per job; power of two, at least 2.
- ADDR_W, 13, BRAM byte-address width.
- DATA_W, 32, BRAM data width; bram_we is DATA_W/8 bits.
- TIMEOUT, 65535, maximum cycles spent in either wait state before the job aborts.

Ports:
- clk  in  1  single clock for all logic and the BRAM port.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  pulse or level; starts a job when sampled in IDLE.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  input stream word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  DATA_W  input stream word.
- ps_control  out  32  bit 0 is start; bits 31:1 are always 0.
- pl_status  in  32  bit 0 is done; other bits ignored.
- bram_addr  out  ADDR_W  byte address, word-aligned (low 2 bits always 0).
- bram_wrdata  out  DATA_W  BRAM write data.
- bram_we  out  DATA_W/8  byte write enables.
- bram_en  out  1  BRAM enable.
- bram_rddata  in  DATA_W  BRAM read data, 1-cycle latency.
- result  out  DATA_W  word read from address 0; held until the next job's result.
- result_valid  out  1  one-cycle pulse when result updates.
- error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset values: all outputs 0, state IDLE, word counter 0, timeout counter 0. result is cleared to 0.
- Reset applied in any state returns to IDLE on the next edge and drops ps_control[0] and bram_we immediately (registered, next edge).
- All BRAM-side outputs and ps_control are registered.
- IDLE: in_ready=0. cmd_start=1 -> LOAD with counter=0.
- LOAD: in_ready=1. When in_valid&&in_ready, the next cycle drives bram_en=1, bram_we=all-ones, bram_addr=counter*4, bram_wrdata=in_data; otherwise bram_we=0 and bram_en=0.
  - in_valid gaps insert idle cycles. Write order is strictly ascending 0..(NWORDS-1)*4.
  - Accepting word NWORDS-1: in_ready drops the following cycle -> START.
  - No data beyond NWORDS is consumed.
- START: set ps_control[0]=1 -> WAIT_DONE. Start is asserted at least one cycle after the last write.
- WAIT_DONE: hold ps_control[0]=1 until pl_status[0]=1, then ps_control[0]=0 -> WAIT_CLR.
- WAIT_CLR: wait for pl_status[0]=0 -> RD_ADDR.
- Timeout counter resets on entry to each wait state. Reaching TIMEOUT in either wait state -> ps_control[0]=0, error pulse, back to IDLE; result is unchanged.
- If pl_status[0]=1 is already high on entry to WAIT_DONE, it is accepted; a stale done is the responder's fault.
- RD_ADDR: bram_en=1, bram_we=0, bram_addr=0 -> RD_DATA.
- RD_DATA: capture bram_rddata into result; result_valid=1 for that one cycle -> IDLE.
- cmd_start outside IDLE is ignored and not queued.
- bram_addr wraps never: the counter width is log2(NWORDS), and the last address is (NWORDS-1)*4.
- Job latency with no stalls is NWORDS + 4 + responder time cycles.

Decomposition:
- Shared package maxval_pkg holds:
  - state enum (IDLE, LOAD, START, WAIT_DONE, WAIT_CLR, RD_ADDR, RD_DATA);
  - CTRL_START_BIT=0 and STATUS_DONE_BIT=0;
  - the default NWORDS and ADDR_W constants.
- No sub-module is needed beyond an optional wait_timer (loadable down-counter with an expired flag) reused by both wait states.

Test Plan:
- Load 2047 $random words plus a final 0xFFFFFFFF. A responder model writes the maximum to address 0 and raises done 20 cycles after start -> 2048 writes at ascending addresses, start held until done, result=0xFFFFFFFF with one result_valid pulse.
- in_valid toggled randomly at 50% -> exactly NWORDS writes, no skipped or duplicated address, last address 0x1FFC.
- Responder never raises done, TIMEOUT=100 -> ps_control[0] falls at cycle 100 of WAIT_DONE, error pulses, busy=0, result unchanged.
- Responder holds done high 50 cycles after start drops -> stays in WAIT_CLR 50 cycles, then reads address 0.
- Reset asserted mid-LOAD at word 500 -> next edge IDLE, bram_we=0, in_ready=0. A new job restarts from address 0.
- cmd_start pulsed during WAIT_DONE -> ignored; exactly one result_valid for the job.
